float_discriminant_arbiter: RTL and testbench
=============================================

Name: float_discriminant_arbiter

Overview:
Round-robin arbiter that shares one float_discriminant instance (or any unit with the same arg_vld/busy/res_vld interface) between N_CLIENTS requesters. It grants one client per issue, forwards that client's a/b/c to the shared unit, and records the owner in an in-order tag FIFO. It routes each returning res/res_negative/err back to the client that issued it. It sits between the client FSMs and the shared FP datapath, in the same clock domain.

Parameters:
N_CLIENTS, 2, number of requesters (2..8)
MAX_OUT, 4, max outstanding issues to the shared unit; equals tag FIFO depth (power of 2)
FLEN, NE: global package constants (double: 64/11), not overridden

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
cli_arg_vld  in  N_CLIENTS  per-client request valid; held until accepted
cli_arg_rdy  out  N_CLIENTS  per-client accept; one-hot or zero
cli_a / cli_b / cli_c  in  N_CLIENTS*FLEN each  flattened operands; client i at [i*FLEN +: FLEN]
cli_res_vld  out  N_CLIENTS  per-client result strobe
cli_res  out  FLEN  result, shared bus, valid where cli_res_vld bit set
cli_res_negative  out  1  pass-through of dn_res_negative
cli_err  out  1  pass-through of dn_err
dn_arg_vld  out  1  issue to shared unit
dn_a / dn_b / dn_c  out  FLEN each  operands of granted client
dn_busy  in  1  shared unit cannot accept
dn_res_vld  in  1  shared unit result strobe
dn_res  in  FLEN  shared unit result
dn_res_negative / dn_err  in  1 each  shared unit flags
busy  out  1  FIFO non-empty or any request pending
protocol_err  out  1  sticky: result arrived with tag FIFO empty

Behaviour:
- Reset (rst=1 at posedge): FIFO empty (wr/rd ptr, count = 0), rr pointer = 0, protocol_err = 0. All combinational outputs gated: cli_arg_rdy = 0, dn_arg_vld = 0, cli_res_vld = 0 while rst=1.
- can_issue = !dn_busy && (count < MAX_OUT || pop_this_cycle). pop_this_cycle = dn_res_vld && count != 0.
- Grant is combinational. Among asserted cli_arg_vld, pick the first index at or after rr pointer, cyclic. Grant only if can_issue.
- Issue cycle: cli_arg_rdy[g] = 1, dn_arg_vld = 1, dn_a/b/c = client g operands (same cycle, zero added latency). Push g into the FIFO. rr pointer <= (g+1) mod N_CLIENTS.
- No grant: rr pointer unchanged. dn_a/b/c = client at rr pointer (don't-care for checking).
- Return: on dn_res_vld with count != 0, cli_res_vld[head] = 1 and the FIFO pops. cli_res/negative/err are pass-through in the same cycle (0-cycle routing latency).
- Results are strictly in issue order; the shared unit is required to return in order.
- dn_res_vld with count == 0: no cli_res_vld, protocol_err <= 1 (sticky until rst).
- Simultaneous push and pop with count == MAX_OUT: allowed, count unchanged. With count == 0: a push-only result does not satisfy the pop.
- Pointers wrap modulo MAX_OUT. count width = clog2(MAX_OUT)+1.
- Client protocol: cli_a/b/c must be stable while cli_arg_vld=1 && cli_arg_rdy=0. A client may have several outstanding issues.
- busy = (count != 0) || |cli_arg_vld.
- Reset mid-operation discards all outstanding tags. The shared unit shares rst, so no stale results are expected.

Test Plan:
- Single client 0: a=1, b=4, c=3 -> cli_arg_rdy[0] and dn_arg_vld in the same cycle; later cli_res_vld=2'b01, cli_res=$realtobits(4.0), cli_err=0.
- Both clients request in the same cycle after reset (client0 a=1,b=4,c=3; client1 a=2,b=10,c=2) -> client0 granted first, client1 next free cycle; client0 gets 4.0 with cli_res_vld=01, client1 gets 84.0 with cli_res_vld=10.
- Both clients hold cli_arg_vld continuously, stub unit never busy -> grants alternate 0,1,0,1; issue order matches the result routing order.
- Stub unit with 20-cycle latency, MAX_OUT=4: 5th request is not granted until the first result returns; it is granted in the same cycle as that pop.
- Overflow: client1 a=1, b=1e200, c=1 -> cli_res_vld=10 with cli_err=1; client0 not strobed.
- Stub asserts dn_res_vld with FIFO empty -> protocol_err=1 and stays 1. Then assert rst with 2 issues outstanding -> protocol_err=0, busy=0, rr pointer=0; first grant after reset goes to client0.

Source files
------------

// File: rtl/float_discriminant_arbiter.sv
// Round-robin front end that shares one arg_vld/busy/res_vld floating-point unit
// between N_CLIENTS requesters, routing in-order results back through a tag FIFO.
package float_discriminant_pkg;
    localparam int FLEN = 64;
endpackage

module float_discriminant_arbiter
    import float_discriminant_pkg::*;
#(
    parameter int N_CLIENTS = 2,
    parameter int MAX_OUT   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_CLIENTS-1:0]      cli_arg_vld,
    output logic [N_CLIENTS-1:0]      cli_arg_rdy,
    input  logic [N_CLIENTS*FLEN-1:0] cli_a,
    input  logic [N_CLIENTS*FLEN-1:0] cli_b,
    input  logic [N_CLIENTS*FLEN-1:0] cli_c,
    output logic [N_CLIENTS-1:0]      cli_res_vld,
    output logic [FLEN-1:0]           cli_res,
    output logic                      cli_res_negative,
    output logic                      cli_err,
    output logic                      dn_arg_vld,
    output logic [FLEN-1:0]           dn_a,
    output logic [FLEN-1:0]           dn_b,
    output logic [FLEN-1:0]           dn_c,
    input  logic                      dn_busy,
    input  logic                      dn_res_vld,
    input  logic [FLEN-1:0]           dn_res,
    input  logic                      dn_res_negative,
    input  logic                      dn_err,
    output logic                      busy,
    output logic                      protocol_err
);
    localparam int TAG_W = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
    localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TAG_W-1:0] rr_q, rr_d;
    logic             perr_q, perr_d;
    logic [TAG_W-1:0] tag_q [MAX_OUT];
    logic [TAG_W-1:0] tag_d [MAX_OUT];

    logic             pop;
    logic             push;
    logic             can_issue;
    logic             found;
    logic [TAG_W-1:0] gnt_idx;
    logic [TAG_W-1:0] cand_idx;
    logic [TAG_W-1:0] head_tag;
    int               cand;

    // First requester at or after the round-robin pointer, cyclically.
    always_comb begin
        found    = 1'b0;
        gnt_idx  = rr_q;
        cand     = 0;
        cand_idx = '0;
        for (int k = 0; k < N_CLIENTS; k++) begin
            cand     = (int'(rr_q) + k) % N_CLIENTS;
            cand_idx = TAG_W'(cand);
            if (!found && cli_arg_vld[cand_idx]) begin
                found   = 1'b1;
                gnt_idx = cand_idx;
            end
        end
    end

    always_comb begin
        pop       = !rst && dn_res_vld && (cnt_q != '0);
        // A full FIFO can still accept an issue in the cycle its head retires.
        can_issue = !dn_busy && ((cnt_q < MAX_CNT) || pop);
        push      = !rst && found && can_issue;
        head_tag  = tag_q[rd_ptr_q];

        cli_arg_rdy = '0;
        if (push) begin
            cli_arg_rdy[gnt_idx] = 1'b1;
        end
        dn_arg_vld = push;

        dn_a = cli_a[FLEN-1:0];
        dn_b = cli_b[FLEN-1:0];
        dn_c = cli_c[FLEN-1:0];
        for (int i = 0; i < N_CLIENTS; i++) begin
            if (gnt_idx == TAG_W'(i)) begin
                dn_a = cli_a[i*FLEN +: FLEN];
                dn_b = cli_b[i*FLEN +: FLEN];
                dn_c = cli_c[i*FLEN +: FLEN];
            end
        end

        cli_res_vld = '0;
        if (pop) begin
            cli_res_vld[head_tag] = 1'b1;
        end
        cli_res          = dn_res;
        cli_res_negative = dn_res_negative;
        cli_err          = dn_err;

        busy         = (cnt_q != '0) || (|cli_arg_vld);
        protocol_err = perr_q;
    end

    always_comb begin
        tag_d = tag_q;
        if (push) begin
            tag_d[wr_ptr_q] = gnt_idx;
        end
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
        rr_d     = rr_q;
        if (push) begin
            rr_d = (int'(gnt_idx) == N_CLIENTS - 1) ? '0 : gnt_idx + TAG_W'(1);
        end
        // A result with nothing outstanding means the shared unit misbehaved.
        perr_d = perr_q || (dn_res_vld && (cnt_q == '0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            rr_q     <= '0;
            perr_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            rr_q     <= rr_d;
            perr_q   <= perr_d;
        end
        tag_q <= tag_d;
    end

endmodule

// File: tb/tb_float_discriminant_arbiter.sv
// Bench for float_discriminant_arbiter: stub discriminant unit (b*b - 4ac) with
// programmable latency, table-driven single-client vectors, and multi-cycle sequences.
module tb_float_discriminant_arbiter;
    import float_discriminant_pkg::*;

    localparam int N = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     cli_arg_vld;
    logic [N-1:0]     cli_arg_rdy;
    logic [N*64-1:0]  cli_a, cli_b, cli_c;
    logic [N-1:0]     cli_res_vld;
    logic [63:0]      cli_res;
    logic             cli_res_negative, cli_err;
    logic             dn_arg_vld;
    logic [63:0]      dn_a, dn_b, dn_c;
    logic             dn_busy;
    logic             dn_res_vld;
    logic [63:0]      dn_res;
    logic             dn_res_negative, dn_err;
    logic             busy, protocol_err;

    int errors = 0;
    int checks = 0;

    int lat       = 3;
    bit stub_spur = 1'b0;

    always #5 clk = ~clk;

    float_discriminant_arbiter #(.N_CLIENTS(2), .MAX_OUT(4)) dut (
        .clk(clk), .rst(rst),
        .cli_arg_vld(cli_arg_vld), .cli_arg_rdy(cli_arg_rdy),
        .cli_a(cli_a), .cli_b(cli_b), .cli_c(cli_c),
        .cli_res_vld(cli_res_vld), .cli_res(cli_res),
        .cli_res_negative(cli_res_negative), .cli_err(cli_err),
        .dn_arg_vld(dn_arg_vld), .dn_a(dn_a), .dn_b(dn_b), .dn_c(dn_c),
        .dn_busy(dn_busy), .dn_res_vld(dn_res_vld), .dn_res(dn_res),
        .dn_res_negative(dn_res_negative), .dn_err(dn_err),
        .busy(busy), .protocol_err(protocol_err)
    );

    // Stub shared unit: in-order, fixed latency, one result per cycle.
    typedef struct {
        int          due;
        logic [63:0] res;
        logic        neg;
        logic        err;
    } stub_t;
    stub_t sq[$];
    int    cyc = 0;
    bit    presented_real = 1'b0;

    initial begin
        stub_t       e;
        real         ra, rb, rc, d;
        bit          spur_now;
        dn_res_vld      = 1'b0;
        dn_res          = '0;
        dn_res_negative = 1'b0;
        dn_err          = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            spur_now = stub_spur;
            if (rst) begin
                sq.delete();
            end else begin
                if (dn_res_vld && presented_real) sq.delete(0);
                if (dn_arg_vld) begin
                    ra = $bitstoreal(dn_a);
                    rb = $bitstoreal(dn_b);
                    rc = $bitstoreal(dn_c);
                    d  = rb * rb - 4.0 * ra * rc;
                    e.res = $realtobits(d);
                    e.neg = (d < 0.0);
                    e.err = (e.res[62:52] == 11'h7FF);
                    e.due = cyc + lat;
                    sq.push_back(e);
                end
            end
            #1;
            dn_res_vld      = 1'b0;
            dn_res          = '0;
            dn_res_negative = 1'b0;
            dn_err          = 1'b0;
            presented_real  = 1'b0;
            if (!rst && spur_now) begin
                dn_res_vld = 1'b1;
                dn_res     = $realtobits(7.0);
            end else if (!rst && sq.size() > 0 && sq[0].due <= cyc) begin
                dn_res_vld      = 1'b1;
                dn_res          = sq[0].res;
                dn_res_negative = sq[0].neg;
                dn_err          = sq[0].err;
                presented_real  = 1'b1;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_ops(input int cl, input real a, input real b, input real c);
        cli_a[cl*64 +: 64] = $realtobits(a);
        cli_b[cl*64 +: 64] = $realtobits(b);
        cli_c[cl*64 +: 64] = $realtobits(c);
    endtask

    task automatic wait_res(output logic [1:0] vld, output logic [63:0] res,
                            output logic neg, output logic err, output bit ok);
        ok  = 1'b0;
        vld = '0;
        res = '0;
        neg = 1'b0;
        err = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (|cli_res_vld) begin
                ok  = 1'b1;
                vld = cli_res_vld;
                res = cli_res;
                neg = cli_res_negative;
                err = cli_err;
            end
        end
    endtask

    typedef struct {
        int          cl;
        real         a, b, c;
        logic [63:0] exp_res;
        logic        exp_neg;
        logic        exp_err;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [1:0]  rv;
        logic [63:0] rres;
        logic        rneg, rerr;
        bit          ok;
        int          iss[8];
        int          rs[8];
        int          g[5];
        int          ni, nr, r0;

        vecs[0] = '{0, 1.0,   4.0,   3.0, $realtobits(4.0),  1'b0, 1'b0};
        vecs[1] = '{1, 2.0,   10.0,  2.0, $realtobits(84.0), 1'b0, 1'b0};
        vecs[2] = '{0, 1.0,   2.0,   3.0, $realtobits(-8.0), 1'b1, 1'b0};
        vecs[3] = '{1, 1.0,   1e200, 1.0, 64'h7FF0000000000000, 1'b0, 1'b1};
        vecs[4] = '{0, 0.5,   3.0,   4.0, $realtobits(1.0),  1'b0, 1'b0};
        vecs[5] = '{1, -1.0,  2.0,   3.0, $realtobits(16.0), 1'b0, 1'b0};

        // Reset with requests pending: all strobes gated.
        rst         = 1'b1;
        dn_busy     = 1'b0;
        cli_arg_vld = 2'b11;
        set_ops(0, 1.0, 4.0, 3.0);
        set_ops(1, 2.0, 10.0, 2.0);
        step();
        step();
        @(negedge clk);
        chk("rst cli_arg_rdy", 64'(cli_arg_rdy), 64'h0);
        chk("rst dn_arg_vld", 64'(dn_arg_vld), 64'h0);
        chk("rst cli_res_vld", 64'(cli_res_vld), 64'h0);
        chk("rst protocol_err", 64'(protocol_err), 64'h0);
        step();
        rst         = 1'b0;
        cli_arg_vld = 2'b00;
        @(negedge clk);
        chk("idle busy", 64'(busy), 64'h0);

        // Single-client vectors.
        for (int v = 0; v < 6; v++) begin
            step();
            set_ops(vecs[v].cl, vecs[v].a, vecs[v].b, vecs[v].c);
            cli_arg_vld = 2'b00;
            cli_arg_vld[vecs[v].cl] = 1'b1;
            @(negedge clk);
            chk($sformatf("vec%0d rdy", v), 64'(cli_arg_rdy), 64'(2'b01 << vecs[v].cl));
            chk($sformatf("vec%0d dn_arg_vld", v), 64'(dn_arg_vld), 64'h1);
            chk($sformatf("vec%0d dn_b", v), dn_b, $realtobits(vecs[v].b));
            step();
            cli_arg_vld = 2'b00;
            wait_res(rv, rres, rneg, rerr, ok);
            chk($sformatf("vec%0d result seen", v), 64'(ok), 64'h1);
            chk($sformatf("vec%0d res_vld", v), 64'(rv), 64'(2'b01 << vecs[v].cl));
            chk($sformatf("vec%0d res", v), rres, vecs[v].exp_res);
            chk($sformatf("vec%0d neg", v), 64'(rneg), 64'(vecs[v].exp_neg));
            chk($sformatf("vec%0d err", v), 64'(rerr), 64'(vecs[v].exp_err));
        end

        // Shared unit busy blocks the grant.
        step();
        dn_busy     = 1'b1;
        set_ops(1, 1.0, 4.0, 3.0);
        cli_arg_vld = 2'b10;
        @(negedge clk);
        chk("dn_busy rdy", 64'(cli_arg_rdy), 64'h0);
        chk("dn_busy dn_arg_vld", 64'(dn_arg_vld), 64'h0);
        chk("dn_busy busy", 64'(busy), 64'h1);
        step();
        dn_busy = 1'b0;
        @(negedge clk);
        chk("after busy rdy", 64'(cli_arg_rdy), 64'(2'b10));
        step();
        cli_arg_vld = 2'b00;
        wait_res(rv, rres, rneg, rerr, ok);
        chk("after busy res_vld", 64'(rv), 64'(2'b10));

        // Simultaneous requests right after reset: client 0 first.
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_ops(0, 1.0, 4.0, 3.0);
        set_ops(1, 2.0, 10.0, 2.0);
        cli_arg_vld = 2'b11;
        @(negedge clk);
        chk("both rdy first", 64'(cli_arg_rdy), 64'(2'b01));
        chk("both dn_a first", dn_a, $realtobits(1.0));
        step();
        cli_arg_vld = 2'b10;
        @(negedge clk);
        chk("both rdy second", 64'(cli_arg_rdy), 64'(2'b10));
        chk("both dn_a second", dn_a, $realtobits(2.0));
        step();
        cli_arg_vld = 2'b00;
        wait_res(rv, rres, rneg, rerr, ok);
        chk("both res0 vld", 64'(rv), 64'(2'b01));
        chk("both res0", rres, $realtobits(4.0));
        step();
        wait_res(rv, rres, rneg, rerr, ok);
        chk("both res1 vld", 64'(rv), 64'(2'b10));
        chk("both res1", rres, $realtobits(84.0));

        // Continuous requests from both clients: grants alternate.
        step();
        cli_arg_vld = 2'b11;
        ni = 0;
        nr = 0;
        for (int i = 0; i < 300 && nr < 8; i++) begin
            @(negedge clk);
            if (|cli_arg_rdy && ni < 8) begin
                iss[ni] = cli_arg_rdy[1] ? 1 : 0;
                ni++;
            end
            if (|cli_res_vld && nr < 8) begin
                rs[nr] = cli_res_vld[1] ? 1 : 0;
                nr++;
            end
            step();
            if (ni >= 8) cli_arg_vld = 2'b00;
        end
        chk("rr results collected", 64'(nr), 64'd8);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("rr grant %0d", k), 64'(iss[k]), 64'(k % 2));
            chk($sformatf("rr route %0d", k), 64'(rs[k]), 64'(k % 2));
        end

        // 20-cycle latency: fifth issue waits for the first pop, same cycle.
        lat = 20;
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_ops(0, 1.0, 4.0, 3.0);
        cli_arg_vld = 2'b01;
        ni = 0;
        nr = 0;
        r0 = -1;
        for (int i = 0; i < 200 && (ni < 5 || nr < 5); i++) begin
            @(negedge clk);
            if (cli_arg_rdy[0] && ni < 5) begin
                g[ni] = i;
                ni++;
            end
            if (cli_res_vld[0]) begin
                if (nr == 0) r0 = i;
                nr++;
            end
            step();
            if (ni >= 5) cli_arg_vld = 2'b00;
        end
        chk("lat grants", 64'(ni), 64'd5);
        chk("lat results", 64'(nr), 64'd5);
        chk("lat four back-to-back", 64'(g[3] - g[0]), 64'd3);
        chk("lat first result cycle", 64'(r0 - g[0]), 64'd21);
        chk("lat fifth with pop", 64'(g[4]), 64'(r0));

        // Result with nothing outstanding sets the sticky error.
        @(negedge clk);
        chk("perr before", 64'(protocol_err), 64'h0);
        step();
        stub_spur = 1'b1;
        step();
        stub_spur = 1'b0;
        @(negedge clk);
        chk("spurious no strobe", 64'(cli_res_vld), 64'h0);
        step();
        @(negedge clk);
        chk("perr set", 64'(protocol_err), 64'h1);
        for (int i = 0; i < 5; i++) step();
        @(negedge clk);
        chk("perr sticky", 64'(protocol_err), 64'h1);

        // Two outstanding issues from client 0 (pointer moves to 1), then reset.
        step();
        cli_arg_vld = 2'b01;
        ni = 0;
        for (int i = 0; i < 20 && ni < 2; i++) begin
            @(negedge clk);
            if (cli_arg_rdy[0]) ni++;
            step();
            if (ni >= 2) cli_arg_vld = 2'b00;
        end
        chk("pre-reset issues", 64'(ni), 64'd2);
        @(negedge clk);
        chk("pre-reset busy", 64'(busy), 64'h1);
        step();
        rst = 1'b1;
        lat = 3;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("post-reset perr", 64'(protocol_err), 64'h0);
        chk("post-reset busy", 64'(busy), 64'h0);
        step();
        set_ops(0, 1.0, 4.0, 3.0);
        set_ops(1, 2.0, 10.0, 2.0);
        cli_arg_vld = 2'b11;
        @(negedge clk);
        chk("post-reset first grant", 64'(cli_arg_rdy), 64'(2'b01));
        step();
        cli_arg_vld = 2'b10;
        @(negedge clk);
        chk("post-reset second grant", 64'(cli_arg_rdy), 64'(2'b10));
        step();
        cli_arg_vld = 2'b00;
        wait_res(rv, rres, rneg, rerr, ok);
        chk("post-reset res0 vld", 64'(rv), 64'(2'b01));
        chk("post-reset res0", rres, $realtobits(4.0));
        step();
        wait_res(rv, rres, rneg, rerr, ok);
        chk("post-reset res1 vld", 64'(rv), 64'(2'b10));
        chk("post-reset res1", rres, $realtobits(84.0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
